// File: rtl/unidade_pkg.sv
// Shared definitions for the execution stage: opcodes, FSM states, register IDs.
package unidade_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_MUL     = 3'b100;
  localparam logic [2:0] OP_DIV     = 3'b101;
  localparam logic [2:0] OP_SLT     = 3'b110;
  localparam logic [2:0] OP_PASSA_A = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    CALCULA       = 2'b01,
    ESCREVE       = 2'b10,
    ESCREVE_RESTO = 2'b11
  } estado_t;

  localparam logic [1:0] REG_A    = 2'b00;
  localparam logic [1:0] REG_B    = 2'b01;
  localparam logic [1:0] REG_ACC  = 2'b10;
  localparam logic [1:0] REG_ZERO = 2'b11;

  function automatic logic eh_iterativo(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/unidade_execucao_mul_div.sv
// Iterative unsigned MUL (shift-add) / DIV (restoring), one step per cycle.
module mul_div_iterativo #(
  parameter int LARGURA = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic               modo,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic               fim,
  output logic [LARGURA-1:0] produto_quociente,
  output logic [LARGURA-1:0] resto,
  output logic               alto_nao_zero
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  logic [LARGURA-1:0] alto;
  logic [LARGURA-1:0] baixo;
  logic [LARGURA-1:0] m;
  logic               div_q;
  logic               ativo;
  logic [CW-1:0]      cont;

  logic [LARGURA+1:0] x;
  logic [LARGURA+1:0] y;
  logic [LARGURA+1:0] cin;
  logic [LARGURA+1:0] soma;
  logic               ok;
  logic [LARGURA-1:0] alto_n;
  logic [LARGURA-1:0] baixo_n;

  // One adder serves both: add multiplicand, or subtract divisor (two's complement).
  always_comb begin
    x   = '0;
    y   = '0;
    cin = '0;
    if (div_q) begin
      x   = {1'b0, alto, baixo[LARGURA-1]};
      y   = ~{2'b00, m};
      cin = {{(LARGURA+1){1'b0}}, 1'b1};
    end else begin
      x = {2'b00, alto};
      y = baixo[0] ? {2'b00, m} : '0;
    end
    soma = x + y + cin;
    ok   = ~soma[LARGURA+1];
    if (div_q) begin
      alto_n  = ok ? soma[LARGURA-1:0]
                   : {alto[LARGURA-2:0], baixo[LARGURA-1]};
      baixo_n = {baixo[LARGURA-2:0], ok};
    end else begin
      alto_n  = soma[LARGURA:1];
      baixo_n = {soma[0], baixo[LARGURA-1:1]};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      alto  <= '0;
      baixo <= '0;
      m     <= '0;
      div_q <= 1'b0;
      ativo <= 1'b0;
      cont  <= '0;
    end else if (start) begin
      alto  <= '0;
      baixo <= modo ? a : b;
      m     <= modo ? b : a;
      div_q <= modo;
      ativo <= 1'b1;
      cont  <= '0;
    end else if (ativo) begin
      alto  <= alto_n;
      baixo <= baixo_n;
      cont  <= cont + 1'b1;
      if (cont == ULTIMO)
        ativo <= 1'b0;
    end
  end

  assign fim               = ativo && (cont == ULTIMO);
  assign produto_quociente = baixo_n;
  assign resto             = alto_n;
  assign alto_nao_zero     = |alto_n;

endmodule

// File: rtl/unidade_execucao.sv
// Execution stage: FSM, single-cycle ALU, flags and bank write-back.
// Define UNIDADE_EXECUCAO_RESTO_EN to also write the DIV remainder to reg B.
module unidade_execucao
  import unidade_pkg::*;
#(
  parameter int         LARGURA    = 32,
  parameter logic [1:0] ID_DESTINO = 2'b10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Inicio,
  input  logic [2:0]         Operacao,
  input  logic [LARGURA-1:0] OperandoA,
  input  logic [LARGURA-1:0] OperandoB,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [LARGURA-1:0] Resultado,
  output logic               Overflow,
  output logic               Erro,
  output logic               Escrita,
  output logic [1:0]         IdReg,
  output logic [LARGURA-1:0] Dado
);

`ifdef UNIDADE_EXECUCAO_RESTO_EN
  localparam bit RESTO_EN = 1'b1;
`else
  localparam bit RESTO_EN = 1'b0;
`endif

  estado_t            estado;
  logic [2:0]         op_q;
  logic [LARGURA-1:0] a_q;
  logic [LARGURA-1:0] b_q;
  logic [LARGURA-1:0] resto_q;

  logic               md_start;
  logic               md_fim;
  logic [LARGURA-1:0] md_pq;
  logic [LARGURA-1:0] md_resto;
  logic               md_alto;

  logic [LARGURA-1:0] soma;
  logic [LARGURA-1:0] dif;
  logic [LARGURA-1:0] alu;
  logic               alu_ovf;
  logic               div_zero;

  assign md_start = (estado == OCIOSO) && Inicio
                 && ((Operacao == OP_MUL)
                  || ((Operacao == OP_DIV) && (OperandoB != '0)));

  assign div_zero = (op_q == OP_DIV) && (b_q == '0);

  mul_div_iterativo #(.LARGURA(LARGURA)) u_mul_div (
    .Clock             (Clock),
    .Reset             (Reset),
    .start             (md_start),
    .modo              (Operacao == OP_DIV),
    .a                 (OperandoA),
    .b                 (OperandoB),
    .fim               (md_fim),
    .produto_quociente (md_pq),
    .resto             (md_resto),
    .alto_nao_zero     (md_alto)
  );

  always_comb begin
    soma    = a_q + b_q;
    dif     = a_q - b_q;
    alu     = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu     = soma;
        alu_ovf = (a_q[LARGURA-1] == b_q[LARGURA-1])
               && (soma[LARGURA-1] != a_q[LARGURA-1]);
      end
      OP_SUB: begin
        alu     = dif;
        alu_ovf = (a_q[LARGURA-1] != b_q[LARGURA-1])
               && (dif[LARGURA-1] != a_q[LARGURA-1]);
      end
      OP_AND:     alu = a_q & b_q;
      OP_OR:      alu = a_q | b_q;
      OP_SLT:     alu = {{(LARGURA-1){1'b0}},
                         $signed(a_q) < $signed(b_q)};
      OP_PASSA_A: alu = a_q;
      default:    alu = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado    <= OCIOSO;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      resto_q   <= '0;
      Ocupado   <= 1'b0;
      Pronto    <= 1'b0;
      Resultado <= '0;
      Overflow  <= 1'b0;
      Erro      <= 1'b0;
      Escrita   <= 1'b0;
      IdReg     <= REG_A;
      Dado      <= '0;
    end else begin
      Pronto  <= 1'b0;
      Escrita <= 1'b0;
      IdReg   <= REG_A;
      Dado    <= '0;
      unique case (estado)
        OCIOSO: begin
          if (Inicio) begin
            op_q     <= Operacao;
            a_q      <= OperandoA;
            b_q      <= OperandoB;
            Overflow <= 1'b0;
            Erro     <= 1'b0;
            Ocupado  <= 1'b1;
            estado   <= CALCULA;
          end
        end
        CALCULA: begin
          if (!eh_iterativo(op_q)) begin
            Resultado <= alu;
            Overflow  <= alu_ovf;
            Escrita   <= 1'b1;
            IdReg     <= ID_DESTINO;
            Dado      <= alu;
            Pronto    <= 1'b1;
            estado    <= ESCREVE;
          end else if (div_zero) begin
            Resultado <= '1;
            Erro      <= 1'b1;
            Pronto    <= 1'b1;
            estado    <= ESCREVE;
          end else if (md_fim) begin
            Resultado <= md_pq;
            resto_q   <= md_resto;
            Overflow  <= (op_q == OP_MUL) && md_alto;
            Escrita   <= 1'b1;
            IdReg     <= ID_DESTINO;
            Dado      <= md_pq;
            Pronto    <= !(RESTO_EN && (op_q == OP_DIV));
            estado    <= ESCREVE;
          end
        end
        ESCREVE: begin
          // Successful DIV spends one more cycle writing the remainder.
          if (RESTO_EN && (op_q == OP_DIV) && !Erro) begin
            Escrita <= 1'b1;
            IdReg   <= REG_B;
            Dado    <= resto_q;
            Pronto  <= 1'b1;
            estado  <= ESCREVE_RESTO;
          end else begin
            Ocupado <= 1'b0;
            estado  <= OCIOSO;
          end
        end
        ESCREVE_RESTO: begin
          Ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: begin
          Ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_execucao.sv
// Directed vector bench for unidade_execucao.
module tb_unidade_execucao;
  import unidade_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        Inicio;
  logic [2:0]  Operacao;
  logic [31:0] OperandoA;
  logic [31:0] OperandoB;
  logic        Ocupado;
  logic        Pronto;
  logic [31:0] Resultado;
  logic        Overflow;
  logic        Erro;
  logic        Escrita;
  logic [1:0]  IdReg;
  logic [31:0] Dado;

  int n_cmp  = 0;
  int n_fail = 0;

  unidade_execucao #(.LARGURA(32), .ID_DESTINO(2'b10)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Inicio    (Inicio),
    .Operacao  (Operacao),
    .OperandoA (OperandoA),
    .OperandoB (OperandoB),
    .Ocupado   (Ocupado),
    .Pronto    (Pronto),
    .Resultado (Resultado),
    .Overflow  (Overflow),
    .Erro      (Erro),
    .Escrita   (Escrita),
    .IdReg     (IdReg),
    .Dado      (Dado)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
    logic        er;
    int          lat;
    int          wr;
    logic [31:0] rem;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic aplica(input int idx, input vec_t v);
    int n;
    int wr;
    int oc;
    int badid;
    logic done;
    logic [31:0] dacc;
    logic [31:0] drem;
    n = 0; wr = 0; oc = 0; badid = 0; done = 1'b0;
    dacc = '0; drem = '0;
`ifdef UNIDADE_EXECUCAO_RESTO_EN
    if (v.op == OP_DIV && !v.er) begin
      v.lat = v.lat + 1;
      v.wr  = v.wr + 1;
    end
`endif
    @(negedge Clock);
    Inicio = 1'b1; Operacao = v.op;
    OperandoA = v.a; OperandoB = v.b;
    while (!done && n < 100) begin
      @(negedge Clock);
      Inicio = 1'b0;
      n++;
      if (Ocupado) oc++;
      if (Escrita) begin
        wr++;
        if (IdReg == 2'b10) dacc = Dado;
        else if (IdReg == 2'b01) drem = Dado;
        else badid++;
      end
      if (Pronto) done = 1'b1;
    end
    chk($sformatf("v%0d pronto", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d latencia", idx), n, v.lat);
    chk($sformatf("v%0d ocupado", idx), oc, v.lat);
    chk($sformatf("v%0d resultado", idx), Resultado, v.r);
    chk($sformatf("v%0d overflow", idx), 32'(Overflow), 32'(v.ov));
    chk($sformatf("v%0d erro", idx), 32'(Erro), 32'(v.er));
    chk($sformatf("v%0d escritas", idx), wr, v.wr);
    chk($sformatf("v%0d idreg", idx), badid, 0);
    if (v.wr > 0)
      chk($sformatf("v%0d dado", idx), dacc, v.r);
`ifdef UNIDADE_EXECUCAO_RESTO_EN
    if (v.op == OP_DIV && !v.er)
      chk($sformatf("v%0d resto", idx), drem, v.rem);
`endif
    @(negedge Clock);
    chk($sformatf("v%0d ocioso", idx), 32'(Ocupado), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    logic done;

    tv[0]  = '{OP_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 2, 1, 32'd0};
    tv[1]  = '{OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000,
               1'b1, 1'b0, 2, 1, 32'd0};
    tv[2]  = '{OP_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 2, 1, 32'd0};
    tv[3]  = '{OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF,
               1'b1, 1'b0, 2, 1, 32'd0};
    tv[4]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,
               1'b0, 1'b0, 2, 1, 32'd0};
    tv[5]  = '{OP_OR, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0,
               1'b0, 1'b0, 2, 1, 32'd0};
    tv[6]  = '{OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 2, 1, 32'd0};
    tv[7]  = '{OP_SLT, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 2, 1, 32'd0};
    tv[8]  = '{OP_PASSA_A, 32'h12345678, 32'h9, 32'h12345678,
               1'b0, 1'b0, 2, 1, 32'd0};
    tv[9]  = '{OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33, 1, 32'd0};
    tv[10] = '{OP_MUL, 32'h10000, 32'h10000, 32'd0,
               1'b1, 1'b0, 33, 1, 32'd0};
    tv[11] = '{OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE,
               1'b1, 1'b0, 33, 1, 32'd0};
    tv[12] = '{OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 1, 32'd2};
    tv[13] = '{OP_DIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
               1'b0, 1'b0, 33, 1, 32'd0};
    tv[14] = '{OP_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 2, 0, 32'd0};

    Reset = 1'b0; Inicio = 1'b0; Operacao = 3'b000;
    OperandoA = '0; OperandoB = '0;
    repeat (3) @(negedge Clock);
    chk("rst ocupado", 32'(Ocupado), 32'd0);
    chk("rst pronto", 32'(Pronto), 32'd0);
    chk("rst escrita", 32'(Escrita), 32'd0);
    chk("rst idreg", 32'(IdReg), 32'd0);
    chk("rst dado", Dado, 32'd0);
    chk("rst resultado", Resultado, 32'd0);
    chk("rst flags", {30'd0, Overflow, Erro}, 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < 15; i++)
      aplica(i, tv[i]);

    // Inicio held high while busy and through ESCREVE is ignored.
    @(negedge Clock);
    Inicio = 1'b1; Operacao = OP_MUL; OperandoA = 32'd7; OperandoB = 32'd6;
    @(negedge Clock);
    Operacao = OP_ADD; OperandoA = 32'd1; OperandoB = 32'd1;
    n = 1; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge Clock);
      n++;
      if (Pronto) done = 1'b1;
    end
    chk("busy pronto", 32'(done), 32'd1);
    chk("busy latencia", n, 33);
    chk("busy dado", Dado, 32'd42);
    @(negedge Clock);
    Inicio = 1'b0;
    chk("busy ocioso", 32'(Ocupado), 32'd0);
    @(negedge Clock);
    chk("busy sem fila", 32'(Ocupado), 32'd0);
    chk("busy resultado", Resultado, 32'd42);

    // Reset in the middle of a MUL aborts without write-back.
    @(negedge Clock);
    Inicio = 1'b1; Operacao = OP_MUL; OperandoA = 32'd7; OperandoB = 32'd6;
    @(negedge Clock);
    Inicio = 1'b0;
    repeat (9) @(negedge Clock);
    chk("mid ocupado antes", 32'(Ocupado), 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid ocupado", 32'(Ocupado), 32'd0);
    chk("mid resultado", Resultado, 32'd0);
    chk("mid escrita", 32'(Escrita), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Escrita || Ocupado || Pronto) bad++;
    end
    chk("mid sem escrita", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
